keypad_scan_4x4: RTL

Scans a 4x4 active-low matrix keypad on the EGo1 expansion header and turns debounced key presses into hex digits. Each accepted press shifts one 4-bit digit into a 16-bit entry register, which feeds the `data` input of the 7-segment display driver. The block is the input-side counterpart of the multiplexed display. It drives one column at a time, the way the display drives one digit at a time, and reads the rows back.

---
 rtl/kp_pkg.sv | 25 ++
 rtl/kp_frame_debounce.sv | 53 +++++
 rtl/keypad_scan_4x4.sv | 137 +++++++++++++
 3 files changed

// File: rtl/kp_pkg.sv
// Shared constants and helpers for the 4x4 matrix keypad scanner.
// Key maps are 16 bits with bit r*4+c set when the key at row r, column c is down.
package kp_pkg;

   localparam logic [3:0] COL_RESET = 4'b1110;
   localparam int         KEY_W     = 4;

   localparam logic [0:0] KP_IDLE    = 1'b0;
   localparam logic [0:0] KP_PRESSED = 1'b1;

   function automatic logic kp_single(input logic [15:0] map);
      return (map != 16'h0000) && ((map & (map - 16'h0001)) == 16'h0000);
   endfunction

   // Bit index doubles as the key code because bit r*4+c == {r[1:0], c[1:0]}.
   function automatic logic [KEY_W-1:0] kp_encode(input logic [15:0] map);
      logic [KEY_W-1:0] code;
      code = '0;
      for (int i = 0; i < 16; i++) begin
         if (map[i]) code = KEY_W'(i);
      end
      return code;
   endfunction

endpackage

// File: rtl/kp_frame_debounce.sv
// Frame-level debouncer: a key map is accepted once DEB_FRAMES consecutive frames match.
// stable_nxt is the value stable_map takes at the next edge, so callers can react without extra latency.
module kp_frame_debounce
   import kp_pkg::*;
#(
   parameter int DEB_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] frame,
   input  logic        frame_end,
   output logic [15:0] stable_map,
   output logic [15:0] stable_nxt
);

   localparam int               CNT_W   = $clog2(DEB_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_FRAMES);

   logic [15:0]      prev_frame;
   logic [CNT_W-1:0] stab_cnt;
   logic [CNT_W-1:0] cnt_nxt;

   // stab_cnt never exceeds CNT_MAX, so inequality is enough to saturate.
   always_comb begin
      cnt_nxt    = stab_cnt;
      stable_nxt = stable_map;
      if (frame_end) begin
         if (frame != prev_frame) begin
            cnt_nxt = CNT_W'(1);
         end else if (stab_cnt != CNT_MAX) begin
            cnt_nxt = stab_cnt + CNT_W'(1);
         end
         if (cnt_nxt == CNT_MAX) begin
            stable_nxt = frame;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_frame <= '0;
         stab_cnt   <= '0;
         stable_map <= '0;
      end else begin
         stab_cnt   <= cnt_nxt;
         stable_map <= stable_nxt;
         if (frame_end) begin
            prev_frame <= frame;
         end
      end
   end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 active-low keypad scanner: column rotation, row sampling, frame debounce and key-entry register.
// key_valid is a one-cycle strobe with no back-pressure; key_code and data hold from the strobe until the next key.
module keypad_scan_4x4
   import kp_pkg::*;
#(
   parameter int SCAN_DIV   = 100_000,
   parameter int DEB_FRAMES = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [3:0]       row_n,
   output logic [3:0]       col_n,
   output logic             key_valid,
   output logic [KEY_W-1:0] key_code,
   output logic             key_down,
   output logic [15:0]      data
);

   localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [3:0]       row_s1;
   logic [3:0]       row_s2;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [1:0]       col_idx;
   logic [15:0]      frame_reg;
   logic [15:0]      frame_full;
   logic             frame_end;
   logic [15:0]      stable_map;
   logic [15:0]      stable_nxt;
   logic             map_upd;
   logic [KEY_W-1:0] new_code;
   logic [0:0]       state;

   // Rows idle high through the pull-ups, so the synchronizer resets to all ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= row_n;
         row_s2 <= row_s1;
      end
   end

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_comb begin
      case (col_n)
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: col_idx = 2'd0;
      endcase
   end

   // The sample taken on the column-3 tick completes the frame in the same cycle.
   always_comb begin
      frame_full = frame_reg;
      for (int r = 0; r < 4; r++) begin
         frame_full[r*4 + int'(col_idx)] = ~row_s2[r];
      end
   end

   assign frame_end = tick && (col_idx == 2'd3);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_n     <= COL_RESET;
         frame_reg <= '0;
      end else if (tick) begin
         col_n     <= {col_n[2:0], col_n[3]};
         frame_reg <= frame_full;
      end
   end

   kp_frame_debounce #(
      .DEB_FRAMES(DEB_FRAMES)
   ) u_debounce (
      .clk       (clk),
      .rst       (rst),
      .frame     (frame_full),
      .frame_end (frame_end),
      .stable_map(stable_map),
      .stable_nxt(stable_nxt)
   );

   assign map_upd  = frame_end && (stable_nxt != stable_map);
   assign new_code = kp_encode(stable_nxt);
   assign key_down = (state == KP_PRESSED);

   // Only a change of the stable map can move the FSM; multi-key maps are ignored in both states.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= KP_IDLE;
         key_valid <= 1'b0;
         key_code  <= '0;
         data      <= '0;
      end else begin
         key_valid <= 1'b0;
         if (map_upd) begin
            case (state)
               KP_IDLE: begin
                  if (kp_single(stable_nxt)) begin
                     state     <= KP_PRESSED;
                     key_valid <= 1'b1;
                     key_code  <= new_code;
                     data      <= {data[11:0], new_code};
                  end
               end
               KP_PRESSED: begin
                  if (stable_nxt == 16'h0000) begin
                     state <= KP_IDLE;
                  end
               end
               default: state <= KP_IDLE;
            endcase
         end
         if (clr) begin
            data <= '0;
         end
      end
   end

endmodule
